// File: rtl/spi_frame_buffer.sv
// spi_frame_buffer: double-buffered SPI frame receiver for the LED-matrix scan driver.
// Bytes arrive MSB first while frame_cs_i is low. Each byte is decoded to a 3-bit RGB
// value and written row-major into the back buffer. A completed frame becomes the front
// buffer only while the scan driver reports idle.
// Build option: define ASCII_DECODE_EN to decode bytes through the character table.
// Without it, the stored colour is the raw byte[2:0].
module spi_frame_buffer #(
  parameter int ROWS_N = 32,
  parameter int COLS_N = 32
) (
  input  logic                      sclk,
  input  logic                      reset,
  input  logic                      frame_cs_i,
  input  logic                      sdi_i,
  input  logic                      matrix_idle_i,
  input  logic [$clog2(ROWS_N)-1:0] rd_row_i,
  input  logic [$clog2(COLS_N)-1:0] rd_col_i,
  output logic [2:0]                rd_rgb_o,
  output logic                      frame_valid_o,
  output logic                      frame_pending_o,
  output logic                      swapped_o,
  output logic                      frame_err_o,
  output logic                      overrun_o
);

  localparam int CELLS_N = ROWS_N * COLS_N;
  localparam int AW      = $clog2(CELLS_N);
  localparam logic [AW:0] LAST_BYTE = (AW+1)'(CELLS_N - 1);

`ifdef ASCII_DECODE_EN
  // The table needs the whole byte, so keep 7 shifted bits plus the incoming one.
  localparam int SHW = 7;

  function automatic logic [2:0] decode_rgb(input logic [7:0] byte_v);
    case (byte_v)
      8'h4F:   decode_rgb = 3'b101; // 'O'
      8'h4C:   decode_rgb = 3'b011; // 'L'
      8'h4A:   decode_rgb = 3'b011; // 'J'
      8'h49:   decode_rgb = 3'b110; // 'I'
      8'h54:   decode_rgb = 3'b100; // 'T'
      8'h53:   decode_rgb = 3'b010; // 'S'
      8'h5A:   decode_rgb = 3'b001; // 'Z'
      8'h20:   decode_rgb = 3'b000; // ' '
      8'h23:   decode_rgb = 3'b111; // '#'
      default: decode_rgb = 3'b000;
    endcase
  endfunction
`else
  // Raw colour only needs the three least significant bits of each byte.
  localparam int SHW = 2;

  function automatic logic [2:0] decode_rgb(input logic [2:0] byte_v);
    decode_rgb = byte_v;
  endfunction
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_PEND = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t          state_q;
  logic [2:0]      bit_cnt_q;
  logic [AW:0]     byte_cnt_q;
  logic [SHW-1:0]  shift_q;
  logic [SHW:0]    shift_d;
  logic            wr_pend_q;
  logic [2:0]      wr_data_q;
  logic            front_sel_q;
  logic            frame_valid_q;
  logic            frame_pending_q;
  logic            swapped_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic [2:0]      rd_rgb_q;
  logic            cs_prev_q;
  logic            drop_done_q;
  logic [2:0]      mem_q [0:2*CELLS_N-1];

  assign shift_d = {shift_q, sdi_i};

  // Back-buffer write of the decoded byte, one edge after its last bit
  always_ff @(posedge sclk) begin
    if (wr_pend_q) begin
      mem_q[{~front_sel_q, byte_cnt_q[AW-1:0]}] <= wr_data_q;
    end
  end

  // Receive FSM, buffer swap control and registered front-buffer read port
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= 3'd0;
      byte_cnt_q      <= '0;
      shift_q         <= '0;
      wr_pend_q       <= 1'b0;
      wr_data_q       <= 3'b000;
      front_sel_q     <= 1'b0;
      frame_valid_q   <= 1'b0;
      frame_pending_q <= 1'b0;
      swapped_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      overrun_q       <= 1'b0;
      rd_rgb_q        <= 3'b000;
      cs_prev_q       <= 1'b1;
      drop_done_q     <= 1'b0;
    end else begin
      cs_prev_q   <= frame_cs_i;
      swapped_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      // Uses the pre-swap selection, so a read on the swap edge sees the old front.
      rd_rgb_q    <= frame_valid_q ? mem_q[{front_sel_q, rd_row_i, rd_col_i}] : 3'b000;

      case (state_q)
        ST_IDLE: begin
          frame_pending_q <= 1'b0;
          if (!frame_cs_i) begin
            state_q    <= ST_RECV;
            shift_q    <= shift_d[SHW-1:0];
            bit_cnt_q  <= 3'd1;
            byte_cnt_q <= '0;
          end
        end

        ST_RECV: begin
          if (wr_pend_q) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
          end
          if (wr_pend_q && (byte_cnt_q == LAST_BYTE)) begin
            // Final byte lands this edge; any further bits are ignored.
            state_q   <= ST_PEND;
            bit_cnt_q <= 3'd0;
          end else if (frame_cs_i) begin
            state_q     <= ST_IDLE;
            frame_err_q <= 1'b1;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= '0;
          end else begin
            shift_q   <= shift_d[SHW-1:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_pend_q <= 1'b1;
              wr_data_q <= decode_rgb(shift_d);
            end
          end
        end

        ST_PEND: begin
          if (matrix_idle_i) begin
            front_sel_q     <= ~front_sel_q;
            frame_valid_q   <= 1'b1;
            swapped_q       <= 1'b1;
            frame_pending_q <= 1'b0;
          end else begin
            frame_pending_q <= 1'b1;
          end
          if (!frame_cs_i && cs_prev_q) begin
            // New frame started before the swap: discard it in DROP.
            overrun_q   <= 1'b1;
            state_q     <= ST_DROP;
            drop_done_q <= matrix_idle_i;
          end else if (matrix_idle_i) begin
            // Trailing bytes of the completed frame keep cs low; skip them in DROP.
            state_q     <= frame_cs_i ? ST_IDLE : ST_DROP;
            drop_done_q <= 1'b1;
          end
        end

        ST_DROP: begin
          if (!drop_done_q && matrix_idle_i) begin
            front_sel_q     <= ~front_sel_q;
            frame_valid_q   <= 1'b1;
            swapped_q       <= 1'b1;
            frame_pending_q <= 1'b0;
            drop_done_q     <= 1'b1;
          end else begin
            frame_pending_q <= ~drop_done_q;
          end
          if (frame_cs_i && (drop_done_q || matrix_idle_i)) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_rgb_o        = rd_rgb_q;
  assign frame_valid_o   = frame_valid_q;
  assign frame_pending_o = frame_pending_q;
  assign swapped_o       = swapped_q;
  assign frame_err_o     = frame_err_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Directed bench for spi_frame_buffer: frame reception, swap timing, abort, overrun, reset.
module tb_spi_frame_buffer;

  logic       sclk;
  logic       reset;
  logic       frame_cs_i;
  logic       sdi_i;
  logic       matrix_idle_i;
  logic [4:0] rd_row_i;
  logic [4:0] rd_col_i;
  logic [2:0] rd_rgb_o;
  logic       frame_valid_o;
  logic       frame_pending_o;
  logic       swapped_o;
  logic       frame_err_o;
  logic       overrun_o;

  spi_frame_buffer #(.ROWS_N(32), .COLS_N(32)) dut (
    .sclk            (sclk),
    .reset           (reset),
    .frame_cs_i      (frame_cs_i),
    .sdi_i           (sdi_i),
    .matrix_idle_i   (matrix_idle_i),
    .rd_row_i        (rd_row_i),
    .rd_col_i        (rd_col_i),
    .rd_rgb_o        (rd_rgb_o),
    .frame_valid_o   (frame_valid_o),
    .frame_pending_o (frame_pending_o),
    .swapped_o       (swapped_o),
    .frame_err_o     (frame_err_o),
    .overrun_o       (overrun_o)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Expected colours of the uniform fill bytes (ASCII table vs raw byte[2:0]).
`ifdef ASCII_DECODE_EN
  localparam logic [2:0] EXP_HASH = 3'b111;
  localparam logic [2:0] EXP_S    = 3'b010;
  localparam logic [2:0] EXP_I    = 3'b110;
  localparam logic [2:0] EXP_T    = 3'b100;
  localparam bit         ASCII_EN = 1'b1;
`else
  localparam logic [2:0] EXP_HASH = 3'b011;
  localparam logic [2:0] EXP_S    = 3'b011;
  localparam logic [2:0] EXP_I    = 3'b001;
  localparam logic [2:0] EXP_T    = 3'b100;
  localparam bit         ASCII_EN = 1'b0;
`endif

  typedef struct {
    int         row;
    int         col;
    logic [2:0] exp_ascii;
    logic [2:0] exp_raw;
    string      name;
  } rd_vec_t;

  rd_vec_t    vecs [12];
  logic [7:0] pat_chars [9] = '{8'h4F, 8'h4C, 8'h4A, 8'h49, 8'h54, 8'h53, 8'h5A, 8'h23, 8'h41};

  int n_tests = 0;
  int n_fail  = 0;
  int n_swp   = 0;
  int n_err   = 0;
  int n_ovr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and tally the single-cycle pulses.
  task automatic tick();
    @(negedge sclk);
    if (swapped_o)   n_swp++;
    if (frame_err_o) n_err++;
    if (overrun_o)   n_ovr++;
  endtask

  function automatic logic [7:0] frame_byte(input logic [7:0] fill, input bit pat, input int n);
    logic [7:0] b;
    b = fill;
    if (pat) begin
      if (n < 9)        b = pat_chars[n];
      else if (n == 33) b = 8'h54;
      else              b = 8'h20;
    end
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick();
      frame_cs_i = 1'b0;
      sdi_i      = b[i];
    end
  endtask

  task automatic send_frame(input logic [7:0] fill, input bit pat, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      send_byte(frame_byte(fill, pat, k));
    end
  endtask

  task automatic read_chk(input string name, input int row, input int col, input logic [2:0] exp);
    rd_row_i = 5'(row);
    rd_col_i = 5'(col);
    tick();
    check(name, {29'd0, rd_rgb_o}, {29'd0, exp});
  endtask

  initial begin
    vecs[0]  = '{0,  0,  3'b101, 3'b111, "rd_O"};
    vecs[1]  = '{0,  1,  3'b011, 3'b100, "rd_L"};
    vecs[2]  = '{0,  2,  3'b011, 3'b010, "rd_J"};
    vecs[3]  = '{0,  3,  3'b110, 3'b001, "rd_I"};
    vecs[4]  = '{0,  4,  3'b100, 3'b100, "rd_T"};
    vecs[5]  = '{0,  5,  3'b010, 3'b011, "rd_S"};
    vecs[6]  = '{0,  6,  3'b001, 3'b010, "rd_Z"};
    vecs[7]  = '{0,  7,  3'b111, 3'b011, "rd_hash"};
    vecs[8]  = '{0,  8,  3'b000, 3'b001, "rd_A"};
    vecs[9]  = '{1,  1,  3'b100, 3'b100, "rd_byte33_T"};
    vecs[10] = '{1,  0,  3'b000, 3'b000, "rd_byte32_sp"};
    vecs[11] = '{31, 31, 3'b000, 3'b000, "rd_last_sp"};

    reset = 1'b1; frame_cs_i = 1'b1; sdi_i = 1'b0; matrix_idle_i = 1'b0;
    rd_row_i = 5'd0; rd_col_i = 5'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    read_chk("rst_rd00", 0, 0, 3'b000);
    check("rst_valid",   {31'd0, frame_valid_o},   32'd0);
    check("rst_pending", {31'd0, frame_pending_o}, 32'd0);
    check("rst_swapped", {31'd0, swapped_o},       32'd0);

    // Frame A: all '#', held pending while the scan driver is busy
    send_frame(8'h23, 1'b0, 1024);
    tick(); frame_cs_i = 1'b1;
    check("pend_t1", {31'd0, frame_pending_o}, 32'd0);
    tick();
    check("pend_t2", {31'd0, frame_pending_o}, 32'd0);
    tick();
    check("pend_t3", {31'd0, frame_pending_o}, 32'd1);
    check("valid_before_swap", {31'd0, frame_valid_o}, 32'd0);
    read_chk("rd_before_swap", 31, 31, 3'b000);
    check("pend_hold", {31'd0, frame_pending_o}, 32'd1);

    // Swap edge: read still returns the old front, next read the new one
    n_swp = 0;
    matrix_idle_i = 1'b1;
    read_chk("rd_on_swap", 31, 31, 3'b000);
    check("swap_pulse",      {31'd0, swapped_o},       32'd1);
    check("swap_valid",      {31'd0, frame_valid_o},   32'd1);
    check("swap_pend_clear", {31'd0, frame_pending_o}, 32'd0);
    matrix_idle_i = 1'b0;
    read_chk("rd_after_swap", 31, 31, EXP_HASH);
    check("swap_pulse_end", {31'd0, swapped_o}, 32'd0);
    repeat (3) tick();
    check("swap_count", n_swp, 32'd1);

    // Frame B: decode table pattern, byte 33 = 'T', rest ' '
    send_frame(8'h20, 1'b1, 1024);
    tick(); frame_cs_i = 1'b1;
    tick(); tick();
    matrix_idle_i = 1'b1;
    tick();
    matrix_idle_i = 1'b0;
    tick();
    for (int v = 0; v < 12; v++) begin
      read_chk(vecs[v].name, vecs[v].row, vecs[v].col,
               ASCII_EN ? vecs[v].exp_ascii : vecs[v].exp_raw);
    end

    // Aborted frame after 500 bytes of 'O'
    n_err = 0; n_swp = 0;
    send_frame(8'h4F, 1'b0, 500);
    tick(); frame_cs_i = 1'b1;
    tick();
    check("err_pulse", {31'd0, frame_err_o}, 32'd1);
    repeat (4) tick();
    check("err_count",   n_err, 32'd1);
    check("err_pending", {31'd0, frame_pending_o}, 32'd0);
    check("err_no_swap", n_swp, 32'd0);
    read_chk("err_front_T",  1, 1, EXP_T);
    read_chk("err_front_sp", 5, 5, 3'b000);

    // Overrun: frame C ('S') pending, frame D ('Z') starts and must be discarded
    n_ovr = 0; n_swp = 0;
    send_frame(8'h53, 1'b0, 1024);
    tick(); frame_cs_i = 1'b1;
    tick(); tick();
    check("pend_c", {31'd0, frame_pending_o}, 32'd1);
    send_frame(8'h5A, 1'b0, 20);
    tick(); frame_cs_i = 1'b1;
    tick(); tick();
    check("ovr_count",   n_ovr, 32'd1);
    check("ovr_pending", {31'd0, frame_pending_o}, 32'd1);
    check("ovr_no_swap", n_swp, 32'd0);
    matrix_idle_i = 1'b1;
    tick();
    check("ovr_swap", {31'd0, swapped_o}, 32'd1);
    matrix_idle_i = 1'b0;
    tick();
    read_chk("ovr_rd00",   0,  0,  EXP_S);
    read_chk("ovr_rd3131", 31, 31, EXP_S);
    read_chk("ovr_rd0019", 0,  19, EXP_S);

    // Reset in the middle of a frame, then a clean frame E ('I')
    send_frame(8'h4C, 1'b0, 700);
    tick();
    reset = 1'b1; frame_cs_i = 1'b1;
    tick();
    check("mrst_rgb",     {29'd0, rd_rgb_o},       32'd0);
    check("mrst_valid",   {31'd0, frame_valid_o},   32'd0);
    check("mrst_pending", {31'd0, frame_pending_o}, 32'd0);
    check("mrst_err",     {31'd0, frame_err_o},     32'd0);
    check("mrst_ovr",     {31'd0, overrun_o},       32'd0);
    reset = 1'b0;
    tick(); tick();
    read_chk("mrst_rd00", 0, 0, 3'b000);
    n_err = 0; n_swp = 0;
    send_frame(8'h49, 1'b0, 1024);
    tick(); frame_cs_i = 1'b1;
    tick(); tick();
    check("e_pending", {31'd0, frame_pending_o}, 32'd1);
    matrix_idle_i = 1'b1;
    tick();
    check("e_swap", {31'd0, swapped_o}, 32'd1);
    matrix_idle_i = 1'b0;
    tick();
    read_chk("e_rd1709", 17, 9, EXP_I);
    check("e_valid", {31'd0, frame_valid_o}, 32'd1);
    check("e_no_err", n_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_buffer.md
# spi_frame_buffer

Double-buffered frame receiver between the SPI link and the LED-matrix scan driver. It shifts a full 32x32 board of one byte per cell in from the host, decodes each byte to a 3-bit RGB colour, and writes it into a back buffer. A completed frame swaps to the front only while the scan driver reports idle, so the panel never shows a torn frame. The scan driver reads the front buffer through a 1-cycle registered read port.

## Interface
- ROWS_N, 32: rows per frame; must be a power of 2.
- COLS_N, 32: columns per frame; must be a power of 2.
- sclk  in  1  clock; SPI clock, also clocks the scan driver.
- reset  in  1  asynchronous, active-high.
- frame_cs  in  1  active-low frame select; held low for the whole frame.
- sdi  in  1  serial data, MSB first, sampled on rising sclk.
- matrix_idle  in  1  scan driver has finished a refresh pass; swap permitted.
- rd_row  in  log2(ROWS_N)  read row, from the scan driver.
- rd_col  in  log2(COLS_N)  read column.
- rd_rgb  out  3  {R,G,B} of the front-buffer cell; 1-cycle latency.
- frame_valid  out  1  at least one frame has been swapped to the front.
- frame_pending  out  1  a complete frame is waiting for a swap.
- swapped  out  1  one-cycle pulse on a buffer swap.
- frame_err  out  1  one-cycle pulse when a frame is aborted short.
- overrun  out  1  one-cycle pulse when a frame starts while one is still pending.

## Operation
- Storage: two buffers, each ROWS_N*COLS_N x 3 bits. front_sel selects the displayed buffer; the other is the back buffer. Buffer contents are not reset.
- Address mapping: byte n of a frame goes to row n/COLS_N, col n%COLS_N (row-major).
- Counters: bit_cnt (3 bits), byte_cnt (log2(ROWS_N*COLS_N)+1 bits).
- FSM states: IDLE, RECV, PEND, DROP.
- IDLE:
  - A frame_cs=0 sample enters RECV. That same edge shifts sdi as bit 7 of byte 0.
- RECV:
  - Each frame_cs=0 edge shifts sdi into an 8-bit shift register.
  - On the 8th bit, the decoded byte is written to the back buffer at byte_cnt on the next edge, and byte_cnt increments.
  - After byte ROWS_N*COLS_N-1 is written, go to PEND.
  - frame_cs=1 before then: pulse frame_err and return to IDLE. The partial byte is discarded; the back buffer holds partial data that is never displayed.
- PEND:
  - frame_pending=1.
  - On an edge with matrix_idle=1: toggle front_sel, set frame_valid, pulse swapped, return to IDLE.
  - If frame_cs is sampled 0 while in PEND: pulse overrun once and go to DROP.
- DROP:
  - All data is ignored while frame_cs=0. The pending frame is still swapped when matrix_idle=1.
  - Exit to IDLE once both frame_cs=1 and the swap has occurred.
- Extra bytes after a complete frame, with frame_cs still low, are ignored; there is no overrun unless a new frame_cs falling edge occurs.
- Read port: rd_rgb <= front[rd_row][rd_col] every edge. It reads 3'b000 while frame_valid=0.
- Simultaneous swap and read: a read on the swap edge returns the old front buffer; the next read uses the new one.
- Reset mid-frame: everything returns to reset state immediately and the partial frame is lost.

## Timing
- Reset values:
  - State IDLE, counters 0, front_sel=0.
  - Outputs: rd_rgb=000, frame_valid=0, frame_pending=0, swapped=0, frame_err=0, overrun=0.
- Byte-to-buffer write: 1 sclk after the 8th bit edge.
- Last bit of a frame to frame_pending=1: 2 sclk.
- Swap: on the first edge in PEND with matrix_idle=1. swapped is high for exactly that following cycle.
- rd_rgb: valid 1 sclk after rd_row/rd_col are presented.
- Minimum frame length: ROWS_N*COLS_N*8 sclk edges with frame_cs low.

## Configuration
- ASCII_DECODE_EN defined: bytes decode by this table; everything else maps to 000.
  - 'O'=101
  - 'L'=011, 'J'=011
  - 'I'=110
  - 'T'=100
  - 'S'=010
  - 'Z'=001
  - ' '=000
  - '#'=111
- Undefined: the stored colour is byte[2:0] raw, with no table.

## Test plan
- Reset, then read (0,0) -> rd_rgb=000, frame_valid=0.
- With ASCII_DECODE_EN: send a 1024-byte frame of all '#' with matrix_idle=0 -> frame_pending=1 and rd_rgb=000. Raise matrix_idle -> swapped pulses once; read (31,31) -> 111.
- Frame with byte 33 = 'T', rest ' ' -> read (1,1) -> 100, (1,0) -> 000.
- frame_cs high after 500 bytes -> frame_err pulses once; frame_pending stays 0; front content unchanged.
- Second frame_cs low while PEND with matrix_idle=0 -> overrun pulses once. Then matrix_idle=1 -> first frame swaps; second frame's data is absent.
- Assert reset at byte 700 -> all outputs return to reset values; a following full frame completes normally.
